// File: rtl/usrt_tx_section.sv
// Buffered USRT transmitter: a word FIFO feeding a start/data/parity/stop serialiser
// that advances one bit per bit_pedge strobe, with rts bracketing each burst of frames.
module usrt_tx_section #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_pedge,
    input  logic                          run_flag,
    input  logic                          size_flag,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          rts,
    output logic                          txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level;
    logic [DATA_W-1:0]   sr;
    logic                par_acc;
    logic                full_frame;
    logic [CW-1:0]       bit_cnt;
    logic                stop_cnt;
    logic [CW-1:0]       nbits;
    logic                push;
    logic                pop;
    logic                last_stop;
    logic                last_data;
    logic                shift_en;

    function automatic logic parity_bit(input logic acc);
        return acc ^ 1'(PARITY_ODD);
    endfunction

    assign wr_ready   = (level != LW'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready;
    assign nbits      = full_frame ? CW'(DATA_W) : CW'(DATA_W / 2);
    assign last_data  = (bit_cnt == nbits);
    assign last_stop  = (state == STOP) && (stop_cnt == 1'(STOP_BITS - 1));
    // A word leaves the FIFO only when a frame is about to start on this strobe
    assign pop        = bit_pedge && run_flag && (level != '0) && ((state == IDLE) || last_stop);
    assign shift_en   = bit_pedge && ((state == START) || ((state == DATA) && !last_data));
    assign busy       = (state != IDLE);
    assign fifo_level = level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Shift register and running parity of the bits already placed on txd
    always_ff @(posedge clk) begin
        if (pop) begin
            sr      <= mem[rd_ptr];
            par_acc <= 1'b0;
        end else if (shift_en) begin
            sr      <= sr >> 1;
            par_acc <= par_acc ^ sr[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            txd        <= 1'b1;
            rts        <= 1'b0;
            full_frame <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
        end else if (bit_pedge) begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        full_frame <= size_flag;
                        txd        <= 1'b0;
                        rts        <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    txd     <= sr[0];
                    bit_cnt <= CW'(1);
                    state   <= DATA;
                end
                DATA: begin
                    if (last_data) begin
                        stop_cnt <= 1'b0;
                        if (PARITY_EN != 0) begin
                            txd   <= parity_bit(par_acc);
                            state <= PARITY;
                        end else begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end
                    end else begin
                        txd     <= sr[0];
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                PARITY: begin
                    txd      <= 1'b1;
                    stop_cnt <= 1'b0;
                    state    <= STOP;
                end
                STOP: begin
                    if (!last_stop) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end else if (pop) begin
                        full_frame <= size_flag;
                        txd        <= 1'b0;
                        state      <= START;
                    end else begin
                        txd   <= 1'b1;
                        rts   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usrt_tx_section.sv
// Bench for usrt_tx_section: an even-parity/1-stop instance and an odd-parity/2-stop
// instance, each frame compared bit by bit against a word-level reference model.
module tb_usrt_tx_section;
    logic       clk = 1'b0;
    logic       rst;
    logic       bit_pedge;
    logic       run_flag;
    logic       size_flag;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       sel;

    logic       wr_ready_a, busy_a, rts_a, txd_a;
    logic       wr_ready_b, busy_b, rts_b, txd_b;
    logic [2:0] fifo_level_a, fifo_level_b;

    logic       wr_ready_s, busy_s, rts_s, txd_s;
    logic [2:0] fifo_level_s;

    typedef logic [8:0] ent_t;
    ent_t qa[$];
    ent_t qb[$];
    bit   exp_bits[16];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    usrt_tx_section #(.DATA_W(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .bit_pedge(bit_pedge), .run_flag(run_flag), .size_flag(size_flag),
        .wr_data(wr_data), .wr_valid(wr_valid && !sel), .wr_ready(wr_ready_a),
        .fifo_level(fifo_level_a), .busy(busy_a), .rts(rts_a), .txd(txd_a));

    usrt_tx_section #(.DATA_W(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .bit_pedge(bit_pedge), .run_flag(run_flag), .size_flag(size_flag),
        .wr_data(wr_data), .wr_valid(wr_valid && sel), .wr_ready(wr_ready_b),
        .fifo_level(fifo_level_b), .busy(busy_b), .rts(rts_b), .txd(txd_b));

    assign wr_ready_s   = sel ? wr_ready_b   : wr_ready_a;
    assign busy_s       = sel ? busy_b       : busy_a;
    assign rts_s        = sel ? rts_b        : rts_a;
    assign txd_s        = sel ? txd_b        : txd_a;
    assign fifo_level_s = sel ? fifo_level_b : fifo_level_a;

    // One-cycle strobe in every 17 clocks
    initial begin
        bit_pedge = 1'b0;
        forever begin
            repeat (16) @(negedge clk);
            bit_pedge = 1'b1;
            @(negedge clk);
            bit_pedge = 1'b0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%0h model=%0h sel=%0d t=%0t", tag, got, exp, sel, $time);
        end
    endtask

    task automatic wait_strobe();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!bit_pedge && n < 40);
        check_val("strobe_seen", 32'(bit_pedge), 32'd1);
        #1;
    endtask

    // Expected line levels for one frame, built from the word and the frame rules
    task automatic build_frame(input logic [7:0] w, input bit full, input bit podd,
                               input int stops, output int len);
        int nb;
        int ones;
        nb   = full ? 8 : 4;
        ones = 0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            exp_bits[1 + i] = ((w >> i) & 8'd1) != 0;
            ones += (w >> i) & 1;
        end
        exp_bits[nb + 1] = ((ones % 2) == 1) ^ podd;
        for (int s = 0; s < stops; s++) exp_bits[nb + 2 + s] = 1'b1;
        len = nb + 2 + stops;
    endtask

    task automatic push(input logic [7:0] w, input bit full);
        @(negedge clk);
        wr_data  = w;
        wr_valid = 1'b1;
        if (sel && qb.size() < 4) qb.push_back({full, w});
        else if (!sel && qa.size() < 4) qa.push_back({full, w});
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic set_size_front();
        if (sel && qb.size() > 0) size_flag = qb[0][8];
        else if (!sel && qa.size() > 0) size_flag = qa[0][8];
    endtask

    task automatic check_frame(input bit first_now, input int drop_at, input int abort_at);
        ent_t e;
        int   len;
        int   lvl;
        if (sel) e = qb.pop_front();
        else     e = qa.pop_front();
        lvl = sel ? qb.size() : qa.size();
        build_frame(e[7:0], e[8], sel, sel ? 2 : 1, len);
        for (int k = 0; k < len; k++) begin
            if (!(k == 0 && first_now)) wait_strobe();
            check_val($sformatf("txd_bit%0d", k), 32'(txd_s), 32'(exp_bits[k]));
            check_val("rts_in_frame", 32'(rts_s), 32'd1);
            check_val("busy_in_frame", 32'(busy_s), 32'd1);
            if (k == 0) begin
                check_val("level_after_pop", 32'(fifo_level_s), 32'(lvl));
                set_size_front();
            end
            if (k == drop_at) run_flag = 1'b0;
            if (k == abort_at) return;
        end
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            wait_strobe();
            check_val("txd_idle", 32'(txd_s), 32'd1);
            check_val("rts_idle", 32'(rts_s), 32'd0);
            check_val("busy_idle", 32'(busy_s), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] w;
        int         n;
        rst = 1'b1; run_flag = 1'b0; size_flag = 1'b1; wr_data = '0; wr_valid = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_val("rst_txd", 32'(txd_s), 32'd1);
            check_val("rst_rts", 32'(rts_s), 32'd0);
            check_val("rst_busy", 32'(busy_s), 32'd0);
            check_val("rst_level", 32'(fifo_level_s), 32'd0);
            check_val("rst_wr_ready", 32'(wr_ready_s), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;

        // Full frame 0xA5, even parity, one stop bit
        sel = 1'b0; size_flag = 1'b1; run_flag = 1'b1;
        push(8'hA5, 1'b1);
        check_val("level_after_push", 32'(fifo_level_s), 32'd1);
        check_frame(1'b0, -1, -1);
        check_idle(2);

        // Half frame 0x3C, odd parity, two stop bits
        sel = 1'b1; size_flag = 1'b0;
        push(8'h3C, 1'b0);
        check_frame(1'b0, -1, -1);
        check_idle(2);

        // Random bursts on both instances
        for (int it = 0; it < 6; it++) begin
            sel = it[0];
            run_flag = 1'b0;
            n = 1 + int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) push(8'($urandom), 1'($urandom));
            set_size_front();
            run_flag = 1'b1;
            for (int i = 0; i < n; i++) check_frame(1'b0, -1, -1);
            check_idle(1);
        end

        // Fill with transmission disabled, overflow push ignored, then drain back-to-back
        sel = 1'b0; run_flag = 1'b0;
        for (int i = 0; i < 4; i++) push(8'($urandom), 1'($urandom));
        check_val("level_full", 32'(fifo_level_s), 32'd4);
        check_val("wr_ready_full", 32'(wr_ready_s), 32'd0);
        push(8'hFF, 1'b1);
        check_val("level_overflow", 32'(fifo_level_s), 32'd4);
        set_size_front();
        run_flag = 1'b1;
        for (int i = 0; i < 4; i++) check_frame(1'b0, -1, -1);
        check_idle(1);

        // run_flag dropped during data bit 3 of the first of two queued frames
        run_flag = 1'b0; size_flag = 1'b1;
        push(8'h96, 1'b1);
        push(8'h5A, 1'b1);
        run_flag = 1'b1;
        check_frame(1'b0, 4, -1);
        check_idle(3);
        check_val("level_held", 32'(fifo_level_s), 32'd1);
        run_flag = 1'b1;
        check_frame(1'b0, -1, -1);
        check_idle(1);

        // Push landing on the start-bit strobe with two words queued
        run_flag = 1'b0;
        push(8'h11, 1'b1);
        push(8'hE7, 1'b0);
        set_size_front();
        @(posedge bit_pedge);
        #1;
        wr_data = 8'h6B; wr_valid = 1'b1; run_flag = 1'b1;
        qa.push_back({1'b1, 8'h6B});
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check_frame(1'b1, -1, -1);
        check_frame(1'b0, -1, -1);
        check_frame(1'b0, -1, -1);
        check_idle(1);

        // Asynchronous reset in the middle of the data bits
        run_flag = 1'b0;
        for (int i = 0; i < 3; i++) push(8'($urandom), 1'b1);
        set_size_front();
        run_flag = 1'b1;
        check_frame(1'b0, -1, 3);
        #2;
        rst = 1'b1;
        #1;
        check_val("abort_txd", 32'(txd_s), 32'd1);
        check_val("abort_rts", 32'(rts_s), 32'd0);
        check_val("abort_busy", 32'(busy_s), 32'd0);
        check_val("abort_level", 32'(fifo_level_s), 32'd0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst = 1'b0;
        check_idle(3);
        check_val("post_abort_level", 32'(fifo_level_s), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
